// File: rtl/demod_acq_ctrl.sv
// Acquisition and lock controller for the QPSK demodulator chain.
// Holds the Costas loop in reset, waits for the loop to settle, then judges
// lock from a windowed |I|-|Q| metric and gates the differential decoder.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | controller disabled, Costas loop / bit sync held in reset
// SETTLE  | loop released, counting valid samples until it settles
// ACQ     | accumulating lock-metric windows, deciding lock or retry
// TRACK   | locked, decoder enabled, watching for consecutive misses
// RESTART | single-cycle loop reset before settling again
// FAIL    | too many failed windows, parked until enable drops
module demod_acq_ctrl #(
   parameter int DW         = 35,
   parameter int MW         = 12,
   parameter int SETTLE_CYC = 1024,
   parameter int WIN_SYMS   = 64,
   parameter int LOCK_THR   = 2048,
   parameter int UNLOCK_THR = 512,
   parameter int MAX_RETRY  = 7
) (
   input  logic                               clk_dds,
   input  logic                               rst,
   input  logic                               enable,
   input  logic                               sample_valid,
   input  logic                               sym_strobe,
   input  logic signed [DW-1:0]               i_data,
   input  logic signed [DW-1:0]               q_data,
   output logic                               loop_rst,
   output logic                               decoder_en,
   output logic                               locked,
   output logic                               fail,
   output logic [2:0]                         state,
   output logic [2:0]                         retry_cnt,
   output logic signed [MW+$clog2(WIN_SYMS):0] metric
);

   localparam int AW  = MW + 1 + $clog2(WIN_SYMS);
   localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int WCW = (WIN_SYMS > 1) ? $clog2(WIN_SYMS) : 1;

   localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE_CYC - 1);
   localparam logic [WCW-1:0]       WIN_LAST    = WCW'(WIN_SYMS - 1);
   localparam logic [2:0]           RETRY_LAST  = 3'(MAX_RETRY - 1);
   localparam logic signed [AW-1:0] LOCK_S      = AW'(LOCK_THR);
   localparam logic signed [AW-1:0] UNLOCK_S    = AW'(UNLOCK_THR);
   localparam logic signed [MW-1:0] MOST_NEG    = {1'b1, {(MW-1){1'b0}}};
   localparam logic [MW-1:0]        MAX_POS     = {1'b0, {(MW-1){1'b1}}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ACQ     = 3'd2,
      ST_TRACK   = 3'd3,
      ST_RESTART = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           retry_q, retry_d;
   logic                 miss_q, miss_d;
   logic [SCW-1:0]       settle_cnt_q, settle_cnt_d;
   logic [WCW-1:0]       sym_cnt_q, sym_cnt_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] metric_q, metric_d;
   logic                 loop_rst_q, loop_rst_d;
   logic                 locked_q, locked_d;
   logic                 fail_q, fail_d;

   logic signed [MW-1:0] i_top, q_top;
   logic [MW-1:0]        i_mag, q_mag;
   logic signed [AW-1:0] term;
   logic signed [AW-1:0] acc_sum;
   logic                 sym_acc;
   logic                 acc_active;
   logic                 win_done;
   logic                 settle_done;
   logic                 unused_lsbs;

   // Magnitude with the most-negative code clamped so it stays in range.
   function automatic logic [MW-1:0] sat_abs(input logic signed [MW-1:0] v);
      logic [MW-1:0] r;
      if (v == MOST_NEG) begin
         r = MAX_POS;
      end else if (v[MW-1]) begin
         r = $unsigned(-v);
      end else begin
         r = $unsigned(v);
      end
      return r;
   endfunction

   assign i_top       = i_data[DW-1 -: MW];
   assign q_top       = q_data[DW-1 -: MW];
   assign unused_lsbs = ^{i_data[DW-MW-1:0], q_data[DW-MW-1:0]};

   // Per-symbol lock term and window bookkeeping.
   always_comb begin
      i_mag       = sat_abs(i_top);
      q_mag       = sat_abs(q_top);
      term        = $signed({{(AW-MW){1'b0}}, i_mag}) - $signed({{(AW-MW){1'b0}}, q_mag});
      acc_sum     = acc_q + term;
      sym_acc     = sym_strobe & sample_valid;
      acc_active  = enable & ((state_q == ST_ACQ) | (state_q == ST_TRACK));
      win_done    = acc_active & sym_acc & (sym_cnt_q == '0);
      settle_done = (state_q == ST_SETTLE) & sample_valid & (settle_cnt_q == '0);
   end

   // State register plus all datapath and output flops.
   always_ff @(posedge clk_dds) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         retry_q      <= '0;
         miss_q       <= 1'b0;
         settle_cnt_q <= SETTLE_LAST;
         sym_cnt_q    <= WIN_LAST;
         acc_q        <= '0;
         metric_q     <= '0;
         loop_rst_q   <= 1'b1;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         miss_q       <= miss_d;
         settle_cnt_q <= settle_cnt_d;
         sym_cnt_q    <= sym_cnt_d;
         acc_q        <= acc_d;
         metric_q     <= metric_d;
         loop_rst_q   <= loop_rst_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
      end
   end

   // Next-state logic, retry accounting and the tracking miss flag.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      miss_d  = miss_q;
      if (!enable) begin
         state_d = ST_IDLE;
         retry_d = '0;
         miss_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_done) begin
                  state_d = ST_ACQ;
               end
            end
            ST_ACQ: begin
               if (win_done) begin
                  if (acc_sum >= LOCK_S) begin
                     state_d = ST_TRACK;
                     retry_d = '0;
                     miss_d  = 1'b0;
                  end else begin
                     retry_d = retry_q + 3'd1;
                     state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_RESTART;
                  end
               end
            end
            ST_TRACK: begin
               if (win_done) begin
                  if (acc_sum < UNLOCK_S) begin
                     if (miss_q) begin
                        state_d = ST_RESTART;
                        miss_d  = 1'b0;
                     end else begin
                        miss_d  = 1'b1;
                     end
                  end else begin
                     miss_d = 1'b0;
                  end
               end
            end
            ST_RESTART: begin
               state_d = ST_SETTLE;
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Settle down-counter, symbol down-counter and window accumulator.
   always_comb begin
      settle_cnt_d = settle_cnt_q;
      sym_cnt_d    = sym_cnt_q;
      acc_d        = acc_q;
      metric_d     = metric_q;

      if (!enable || (state_q != ST_SETTLE)) begin
         settle_cnt_d = SETTLE_LAST;
      end else if (sample_valid) begin
         settle_cnt_d = (settle_cnt_q == '0) ? SETTLE_LAST : settle_cnt_q - SCW'(1);
      end

      // Outside ACQ/TRACK the window is held empty so it starts clean.
      if (!acc_active) begin
         acc_d     = '0;
         sym_cnt_d = WIN_LAST;
      end else if (sym_acc) begin
         if (win_done) begin
            metric_d  = acc_sum;
            acc_d     = '0;
            sym_cnt_d = WIN_LAST;
         end else begin
            acc_d     = acc_sum;
            sym_cnt_d = sym_cnt_q - WCW'(1);
         end
      end
   end

   // Moore outputs decoded from the upcoming state so they register with it.
   always_comb begin
      loop_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESTART);
      locked_d   = (state_d == ST_TRACK);
      fail_d     = (state_d == ST_FAIL);
   end

   assign state      = state_q;
   assign retry_cnt  = retry_q;
   assign metric     = metric_q;
   assign loop_rst   = loop_rst_q;
   assign locked     = locked_q;
   assign decoder_en = locked_q;
   assign fail       = fail_q;

endmodule

// File: tb/tb_demod_acq_ctrl.sv
// Bench for demod_acq_ctrl: a behavioural model predicts every cycle's
// outputs into a scoreboard queue, a monitor pops and compares them, and the
// stimulus process adds directed checks against hand-computed constants.
module tb_demod_acq_ctrl;

   localparam int DW         = 35;
   localparam int MW         = 12;
   localparam int SETTLE_CYC = 1024;
   localparam int WIN_SYMS   = 64;
   localparam int LOCK_THR   = 2048;
   localparam int UNLOCK_THR = 512;
   localparam int MAX_RETRY  = 7;
   localparam int AW         = MW + 1 + $clog2(WIN_SYMS);
   localparam int MAG_MAX    = 2**(MW-1) - 1;
   localparam int WAIT_MAX   = 6000;

   logic                 clk_dds = 1'b0;
   logic                 rst;
   logic                 enable;
   logic                 sample_valid;
   logic                 sym_strobe;
   logic signed [DW-1:0] i_data;
   logic signed [DW-1:0] q_data;
   logic                 loop_rst;
   logic                 decoder_en;
   logic                 locked;
   logic                 fail;
   logic [2:0]           state;
   logic [2:0]           retry_cnt;
   logic signed [AW-1:0] metric;

   demod_acq_ctrl #(
      .DW(DW), .MW(MW), .SETTLE_CYC(SETTLE_CYC), .WIN_SYMS(WIN_SYMS),
      .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk_dds(clk_dds), .rst(rst), .enable(enable), .sample_valid(sample_valid),
      .sym_strobe(sym_strobe), .i_data(i_data), .q_data(q_data),
      .loop_rst(loop_rst), .decoder_en(decoder_en), .locked(locked), .fail(fail),
      .state(state), .retry_cnt(retry_cnt), .metric(metric)
   );

   always #5 clk_dds = ~clk_dds;

   typedef struct {
      int st;
      bit lr;
      bit lk;
      bit fl;
      int rc;
      int met;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_print = 0;
   int   rand_gaps = 0;

   // Reference model state (plain integers, spec-level rules).
   int m_st = 0, m_settle = 0, m_syms = 0, m_acc = 0;
   int m_retry = 0, m_miss = 0, m_metric = 0;

   function automatic int mag(input logic [DW-1:0] x);
      logic signed [MW-1:0] t;
      int v;
      t = x[DW-1 -: MW];
      v = int'(t);
      if (v < 0) v = -v;
      if (v > MAG_MAX) v = MAG_MAX;
      return v;
   endfunction

   function automatic logic [DW-1:0] mk(input int top);
      logic [DW-1:0] r;
      r[DW-1 -: MW]   = top[MW-1:0];
      r[DW-MW-1:0]    = (DW-MW)'($urandom);
      return r;
   endfunction

   // Model: advance on each edge and push the predicted post-edge outputs.
   always @(posedge clk_dds) begin
      exp_t e;
      int   term, sum;
      if (rst) begin
         m_st = 0; m_settle = 0; m_syms = 0; m_acc = 0;
         m_retry = 0; m_miss = 0; m_metric = 0;
      end else if (!enable) begin
         m_st = 0; m_retry = 0; m_miss = 0; m_acc = 0; m_syms = 0;
      end else begin
         case (m_st)
            0: begin m_st = 1; m_settle = 0; end
            1: if (sample_valid) begin
                  if (m_settle == SETTLE_CYC - 1) begin
                     m_st = 2; m_acc = 0; m_syms = 0;
                  end else begin
                     m_settle++;
                  end
               end
            2, 3: if (sym_strobe && sample_valid) begin
                  term = mag(i_data) - mag(q_data);
                  sum  = m_acc + term;
                  m_syms++;
                  if (m_syms == WIN_SYMS) begin
                     m_metric = sum; m_acc = 0; m_syms = 0;
                     if (m_st == 2) begin
                        if (sum >= LOCK_THR) begin
                           m_st = 3; m_retry = 0; m_miss = 0;
                        end else begin
                           m_retry++;
                           m_st = (m_retry == MAX_RETRY) ? 5 : 4;
                        end
                     end else begin
                        if (sum < UNLOCK_THR) begin
                           m_miss++;
                           if (m_miss == 2) begin m_st = 4; m_miss = 0; end
                        end else begin
                           m_miss = 0;
                        end
                     end
                  end else begin
                     m_acc = sum;
                  end
               end
            4: begin m_st = 1; m_settle = 0; end
            default: ;
         endcase
      end
      e.st  = m_st;
      e.lr  = (m_st == 0) || (m_st == 4);
      e.lk  = (m_st == 3);
      e.fl  = (m_st == 5);
      e.rc  = m_retry;
      e.met = m_metric;
      sb_q.push_back(e);
   end

   // Monitor: compare DUT outputs with the oldest prediction, away from the edge.
   always @(negedge clk_dds) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_tests++;
         if (state !== 3'(e.st) || loop_rst !== e.lr || locked !== e.lk ||
             decoder_en !== e.lk || fail !== e.fl || retry_cnt !== 3'(e.rc) ||
             metric !== AW'(e.met)) begin
            n_fail++;
            if (n_print < 30) begin
               n_print++;
               $display("FAIL scoreboard t=%0t got st=%0d lr=%0b lk=%0b den=%0b fl=%0b rc=%0d met=%0d required st=%0d lr=%0b lk=%0b fl=%0b rc=%0d met=%0d",
                        $time, state, loop_rst, locked, decoder_en, fail, retry_cnt, metric,
                        e.st, e.lr, e.lk, e.fl, e.rc, e.met);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk_dds);
   endtask

   task automatic idle_cycle();
      sym_strobe   = 1'b0;
      sample_valid = (rand_gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data       = mk(int'($urandom_range(0, 4095)));
      q_data       = mk(int'($urandom_range(0, 4095)));
      tick();
   endtask

   // Wait (bounded) until the model reaches ACQ or TRACK.
   task automatic wait_run(input string nm);
      int n;
      n = 0;
      while (!(m_st == 2 || m_st == 3) && n < WAIT_MAX) begin
         idle_cycle();
         n++;
      end
      n_tests++;
      if (n >= WAIT_MAX) begin
         n_fail++;
         $display("FAIL %s: timeout waiting for ACQ/TRACK, model state %0d dut state %0d", nm, m_st, state);
      end
   endtask

   // Drive nsym accepted strobes whose |I|-|Q| terms sum to target.
   // mode 0: random magnitudes/signs, 1: I=-2048 Q=0, 2: I=Q=+500.
   task automatic window(input int target, input int mode, input int nsym);
      int base, rem, d, lo, hi, qm, im, iv, qv;
      base = target / WIN_SYMS;
      rem  = target - base * WIN_SYMS;
      for (int k = 0; k < nsym; k++) begin
         if (rand_gaps != 0 && $urandom_range(0, 3) == 0) begin
            sample_valid = 1'b0;
            sym_strobe   = 1'b1;
            i_data       = mk(int'($urandom_range(0, 4095)));
            q_data       = mk(int'($urandom_range(0, 4095)));
            tick();
         end
         d = base + ((k == 0) ? rem : 0);
         case (mode)
            1: begin iv = -2048; qv = 0; end
            2: begin iv = 500; qv = 500; end
            default: begin
               lo = (d < 0) ? -d : 0;
               hi = MAG_MAX - ((d > 0) ? d : 0);
               qm = int'($urandom_range(hi, lo));
               im = qm + d;
               iv = ($urandom_range(0, 1) != 0) ? -im : im;
               qv = ($urandom_range(0, 1) != 0) ? -qm : qm;
            end
         endcase
         sample_valid = 1'b1;
         sym_strobe   = 1'b1;
         i_data       = mk(iv);
         q_data       = mk(qv);
         tick();
         sym_strobe = 1'b0;
         if (k != nsym - 1 && rand_gaps != 0) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
         end
      end
   endtask

   initial begin
      int tgt;
      rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sym_strobe = 1'b0;
      i_data = '0; q_data = '0;

      repeat (3) tick();
      chk("rst_state", state, 0);
      chk("rst_loop_rst", loop_rst, 1);
      chk("rst_flags", {decoder_en, locked, fail, retry_cnt}, 0);
      chk("rst_metric", metric, 0);
      rst = 1'b0;
      repeat (3) tick();
      chk("idle_hold", state, 0);

      enable = 1'b1; sample_valid = 1'b1;
      tick();
      chk("settle_entry", state, 1);
      chk("loop_rst_fall", loop_rst, 0);
      repeat (SETTLE_CYC - 1) tick();
      chk("settle_len_last", state, 1);
      tick();
      chk("settle_to_acq", state, 2);

      window(57600, 0, WIN_SYMS);
      chk("lock_metric", metric, 57600);
      chk("lock_state", state, 3);
      chk("lock_locked", {locked, decoder_en}, 3);

      rand_gaps = 1;
      window(300, 0, WIN_SYMS);
      chk("hyst_miss1_state", state, 3);
      chk("hyst_miss1_metric", metric, 300);
      window(4000, 0, WIN_SYMS);
      chk("hyst_recover", state, 3);
      window(1000, 0, WIN_SYMS);
      chk("hyst_band", state, 3);
      window(300, 0, WIN_SYMS);
      chk("miss_a", state, 3);
      window(300, 0, WIN_SYMS);
      chk("miss_b_restart", state, 4);
      chk("miss_b_unlock", locked, 0);
      chk("miss_b_loop_rst", loop_rst, 1);
      chk("miss_b_retry", retry_cnt, 0);
      idle_cycle();
      chk("restart_one_cycle", state, 1);

      wait_run("retry_start");
      for (int r = 0; r < MAX_RETRY; r++) begin
         window(0, 2, WIN_SYMS);
         chk("retry_metric", metric, 0);
         chk("retry_cnt", retry_cnt, r + 1);
         if (r < MAX_RETRY - 1) begin
            chk("retry_restart", state, 4);
            wait_run("retry_next");
         end else begin
            chk("fail_state", state, 5);
            chk("fail_flag", fail, 1);
         end
      end
      repeat (5) idle_cycle();
      chk("fail_hold", state, 5);
      enable = 1'b0;
      idle_cycle();
      chk("fail_exit_state", state, 0);
      chk("fail_exit_retry", retry_cnt, 0);
      chk("fail_exit_flag", fail, 0);

      enable = 1'b1;
      wait_run("sat_start");
      window(0, 1, WIN_SYMS);
      chk("sat_metric", metric, 131008);
      chk("sat_state", state, 3);

      for (int n = 0; n < 10; n++) begin
         if (m_st == 5) begin
            enable = 1'b0;
            idle_cycle();
            enable = 1'b1;
         end
         wait_run("rand_start");
         tgt = int'($urandom_range(0, 64 * 2900)) - 64 * 1000;
         case ($urandom_range(0, 5))
            0: begin
               window(tgt, 0, int'($urandom_range(5, WIN_SYMS - 5)));
               rst = 1'b1;
               idle_cycle();
               rst = 1'b0;
            end
            1: begin
               window(tgt, 0, int'($urandom_range(5, WIN_SYMS - 5)));
               enable = 1'b0;
               repeat (2) idle_cycle();
               enable = 1'b1;
            end
            default: window(tgt, 0, WIN_SYMS);
         endcase
      end

      sample_valid = 1'b0;
      repeat (5) idle_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demod_acq_ctrl.md
Name: demod_acq_ctrl

Overview:
- Acquisition and lock controller for the QPSK demodulator chain (receive FIR -> Costas loop -> bit sync -> differential decoder), running in the clk_dds domain.
- Sequences the chain: holds the Costas loop in reset, waits for the filter and loop to settle, then judges lock from the Costas I/Q arms.
- Gates the differential decoder while locked, and restarts or declares failure on loss of lock.

Parameters:
- DW, 35, width of Costas i_data/q_data (signed)
- MW, 12, metric bits taken from the top of i_data/q_data
- SETTLE_CYC, 1024, valid samples to wait after a loop reset
- WIN_SYMS, 64, symbols per lock-metric window (power of 2)
- LOCK_THR, 2048, window metric >= this declares lock (signed)
- UNLOCK_THR, 512, window metric < this counts as a miss while tracking
- MAX_RETRY, 7, failed acquisition windows before FAIL

Ports:
- clk_dds  in  1  system/DDS clock, all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  level; 1 = run acquisition, 0 = return to IDLE
- sample_valid  in  1  Costas output valid
- sym_strobe  in  1  one-cycle symbol pulse (bit-sync edge, already in clk_dds domain)
- i_data  in  DW  Costas I arm, signed
- q_data  in  DW  Costas Q arm, signed
- loop_rst  out  1  reset to Costas loop and bit sync
- decoder_en  out  1  enables the differential decoder
- locked  out  1  lock indicator
- fail  out  1  acquisition failed
- state  out  3  IDLE=0, SETTLE=1, ACQ=2, TRACK=3, RESTART=4, FAIL=5
- retry_cnt  out  3  failed acquisition windows since last lock or IDLE
- metric  out  MW+1+log2(WIN_SYMS)  last completed window accumulator, signed

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, loop_rst=1, decoder_en=0, locked=0, fail=0, retry_cnt=0, metric=0.
  - All counters and the accumulator are cleared.
- Outputs are registered Moore outputs decoded from state.
  - loop_rst=1 in IDLE and RESTART.
  - decoder_en=locked=1 in TRACK only.
  - fail=1 in FAIL only.
- enable=0 in any state -> IDLE next cycle, with retry_cnt cleared. This overrides every other transition.
- IDLE: enable=1 -> SETTLE, settle counter cleared.
- SETTLE:
  - The counter increments on each sample_valid.
  - When the count reaches SETTLE_CYC-1 with sample_valid=1 -> ACQ, with the accumulator and symbol counter cleared.
- Metric term, computed on a cycle with sym_strobe & sample_valid:
  - Im = i_data[DW-1 -: MW], Qm = q_data[DW-1 -: MW], both signed.
  - abs() saturates: the most-negative value maps to 2^(MW-1)-1.
  - d = |Im| - |Qm|, sign-extended into the accumulator.
  - A strobe without sample_valid is ignored and not counted.
- Window completion:
  - The window completes on the accepted strobe that makes the symbol count equal WIN_SYMS.
  - The decision uses the accumulator plus the current term. That sum is written to metric.
  - The accumulator restarts at 0 on the next cycle, and no strobe is lost.
- ACQ, on window completion:
  - sum >= LOCK_THR -> TRACK, retry_cnt=0, miss counter=0.
  - Else if retry_cnt == MAX_RETRY-1 -> FAIL, with retry_cnt incremented.
  - Else -> RESTART, with retry_cnt incremented.
- TRACK, on window completion:
  - sum < UNLOCK_THR: miss counter increments. A second consecutive miss -> RESTART (retry_cnt unchanged, 0).
  - sum >= UNLOCK_THR: miss counter clears.
  - Sums in [UNLOCK_THR, LOCK_THR) are hysteresis and keep TRACK.
- RESTART: lasts exactly one cycle with loop_rst=1, then -> SETTLE.
- FAIL: holds until enable=0. The first cycle with enable=0 -> IDLE. No auto-retry.
- Accumulation is performed only in ACQ and TRACK.
- rst mid-window discards the partial accumulator. metric returns to 0.

Test Plan:
- rst=1 for 3 cycles, enable=0 -> state=0, loop_rst=1, all other outputs 0; after rst release with enable=0, state stays 0.
- enable=1, sample_valid=1 constant -> state=1 one cycle after enable, state=2 exactly SETTLE_CYC cycles later; loop_rst falls as state leaves 0.
- In ACQ, 64 strobes with i_data top 12 bits=+1000, q top=+100 -> metric=57600, state=3, locked=decoder_en=1 the cycle after the 64th strobe.
- In ACQ, I=Q=+500 every window -> metric=0, six RESTART pulses (loop_rst high 1 cycle each), retry_cnt reaching 7, then state=5, fail=1; enable=0 -> IDLE next cycle, retry_cnt=0.
- In TRACK, one window at metric=300 then one at 4000 -> stays TRACK. Two consecutive windows at 300 -> RESTART then SETTLE, locked drops the cycle after the second window.
- Saturation: i_data top bits = -2048, q=0 for 64 symbols -> metric=64*2047=131008, and the accumulator does not overflow.
